// File: rtl/onehot_decode_pipe.sv
// Guarded select-to-one-hot decoder feeding a two-entry skid buffer, with a saturating hit counter.
// Optional even-parity input check is enabled by defining DECODE_PARITY_EN.
module onehot_decode_pipe #(
    parameter int unsigned SEL_W       = 4,
    parameter int unsigned GUARD_W     = 5,
    parameter logic [7:0]  GUARD_MATCH = 8'b0001_0001,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned N_OUT      = 1 << SEL_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [SEL_W-1:0]   in_sel_i,
    input  logic [GUARD_W-1:0] in_guard_i,
`ifdef DECODE_PARITY_EN
    input  logic               in_par_i,
`endif
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [N_OUT-1:0]   out_onehot_o,
    output logic               out_hit_o,
    output logic [CNT_W-1:0]   hit_count_o,
    output logic               err_sticky_o
);

    typedef struct packed {
        logic [N_OUT-1:0] onehot;
        logic             hit;
    } word_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q, state_d;
    word_t            head_q, head_d;
    word_t            tail_q, tail_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_ok;
    logic             in_hit;
    word_t            in_word;
    logic             accept;
    logic             pop;

`ifdef DECODE_PARITY_EN
    assign par_ok = ~^{in_sel_i, in_guard_i, in_par_i};
`else
    assign par_ok = 1'b1;
`endif

    assign in_hit         = par_ok && (in_guard_i == GUARD_MATCH[GUARD_W-1:0]);
    assign in_word.hit    = in_hit;
    assign in_word.onehot = in_hit ? (N_OUT'(1) << in_sel_i) : '0;

    assign out_valid_o  = (state_q != StEmpty);
    assign in_ready_o   = in_ready_q;
    assign accept       = in_valid_i & in_ready_q;
    assign pop          = out_valid_o & out_ready_i;
    assign out_onehot_o = head_q.onehot;
    assign out_hit_o    = head_q.hit;
    assign hit_count_o  = cnt_q;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_d  = in_word;
                    state_d = StOne;
                end
            end
            StOne: begin
                // Simultaneous accept and pop keeps occupancy at one: incoming word becomes head.
                if (accept && pop) begin
                    head_d = in_word;
                end else if (accept) begin
                    tail_d  = in_word;
                    state_d = StTwo;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept && in_hit && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= (state_d != StTwo);
            cnt_q      <= cnt_d;
        end
    end

`ifdef DECODE_PARITY_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (accept && !par_ok) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky_o = err_q;
`else
    assign err_sticky_o = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decode_pipe.sv
// Self-checking bench for onehot_decode_pipe: directed scenarios plus randomized traffic
// compared against a queue-based reference model. Parity tests run when DECODE_PARITY_EN is set.
module tb_onehot_decode_pipe;

    localparam int SEL_W   = 4;
    localparam int GUARD_W = 5;
    localparam int CNT_W   = 4;
    localparam int N_OUT   = 16;
    localparam int CNT_MAX = 15;
    localparam logic [4:0] MATCH = 5'b10001;

    typedef struct packed {
        logic [15:0] oh;
        logic        hit;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [SEL_W-1:0]   in_sel;
    logic [GUARD_W-1:0] in_guard;
    logic               in_par;
    logic               out_valid;
    logic               out_ready;
    logic [N_OUT-1:0]   out_onehot;
    logic               out_hit;
    logic [CNT_W-1:0]   hit_count;
    logic               err_sticky;

    int   errors = 0;
    int   checks = 0;
    exp_t mq[$];
    int   m_cnt;
    bit   m_err;

    always #5 clk = ~clk;

    onehot_decode_pipe #(
        .SEL_W  (SEL_W),
        .GUARD_W(GUARD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sel_i    (in_sel),
        .in_guard_i  (in_guard),
`ifdef DECODE_PARITY_EN
        .in_par_i    (in_par),
`endif
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_onehot_o(out_onehot),
        .out_hit_o   (out_hit),
        .hit_count_o (hit_count),
        .err_sticky_o(err_sticky)
    );

    function automatic bit good_par(input logic [3:0] sel, input logic [4:0] guard);
        return ^{sel, guard};
    endfunction

    function automatic bit par_ok(input logic [3:0] sel, input logic [4:0] guard, input bit par);
`ifdef DECODE_PARITY_EN
        return (($countones({sel, guard}) + int'(par)) % 2) == 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic exp_t model_word(input logic [3:0] sel, input logic [4:0] guard,
                                        input bit par);
        exp_t w;
        w.hit = par_ok(sel, guard, par) && (guard == MATCH);
        w.oh  = w.hit ? 16'(2 ** int'(sel)) : 16'h0000;
        return w;
    endfunction

    // Drive one cycle of inputs from a negedge, advance the model at the posedge, return at negedge.
    task automatic drive(input bit v, input logic [3:0] sel, input logic [4:0] guard,
                         input bit par, input bit rdy);
        exp_t w;
        bit   acc;
        bit   pp;
        in_valid  = v;
        in_sel    = sel;
        in_guard  = guard;
        in_par    = par;
        out_ready = rdy;
        w   = model_word(sel, guard, par);
        acc = v && (mq.size() < 2);
        pp  = (mq.size() > 0) && rdy;
        @(posedge clk);
        if (pp) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(w);
            if (w.hit && m_cnt < CNT_MAX) m_cnt++;
            if (!par_ok(sel, guard, par)) m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        drive(1'b0, 4'd0, 5'd0, 1'b0, rdy);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_cnt = 0;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_sel    = '0;
        in_guard  = '0;
        in_par    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_onehot !== 16'h0000 || out_hit !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got %h/%b expected 0000/0", out_onehot, out_hit);
        end
        checks++;
        if (hit_count !== 4'd0 || err_sticky !== 1'b0) begin
            errors++; $display("FAIL reset_cnt_err: got %0d/%b expected 0/0", hit_count, err_sticky);
        end
        rst = 1'b0;
        mq.delete();
        m_cnt = 0;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic_hit();
        drive(1'b1, 4'd6, MATCH, good_par(4'd6, MATCH), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h0040 || out_hit !== 1'b1) begin
            errors++;
            $display("FAIL basic_hit: got v=%b oh=%h hit=%b expected v=1 oh=0040 hit=1",
                     out_valid, out_onehot, out_hit);
        end
        checks++;
        if (hit_count !== 4'd1) begin
            errors++; $display("FAIL basic_hit_count: got %0d expected 1", hit_count);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_miss();
        drive(1'b1, 4'd3, 5'b00000, good_par(4'd3, 5'b00000), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h0000 || out_hit !== 1'b0) begin
            errors++;
            $display("FAIL miss: got v=%b oh=%h hit=%b expected v=1 oh=0000 hit=0",
                     out_valid, out_onehot, out_hit);
        end
        checks++;
        if (hit_count !== 4'd1) begin
            errors++; $display("FAIL miss_count: got %0d expected 1", hit_count);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        drive(1'b1, 4'd1, MATCH, good_par(4'd1, MATCH), 1'b0);
        checks++;
        if (in_ready !== 1'b1 || out_onehot !== 16'h0002) begin
            errors++; $display("FAIL bp_first: got rdy=%b oh=%h expected 1/0002", in_ready, out_onehot);
        end
        drive(1'b1, 4'd9, MATCH, good_par(4'd9, MATCH), 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_onehot !== 16'h0002) begin
            errors++; $display("FAIL bp_full: got rdy=%b oh=%h expected 0/0002", in_ready, out_onehot);
        end
        drive(1'b1, 4'd12, MATCH, good_par(4'd12, MATCH), 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 16'h0002) begin
            errors++;
            $display("FAIL bp_stall: got rdy=%b v=%b oh=%h expected 0/1/0002",
                     in_ready, out_valid, out_onehot);
        end
        drive(1'b1, 4'd12, MATCH, good_par(4'd12, MATCH), 1'b1);
        checks++;
        if (in_ready !== 1'b1 || out_onehot !== 16'h0200) begin
            errors++; $display("FAIL bp_second: got rdy=%b oh=%h expected 1/0200", in_ready, out_onehot);
        end
        drive(1'b1, 4'd12, MATCH, good_par(4'd12, MATCH), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h1000) begin
            errors++; $display("FAIL bp_third: got v=%b oh=%h expected 1/1000", out_valid, out_onehot);
        end
        idle(1'b1);
        checks++;
        if (out_valid !== 1'b0 || hit_count !== 4'd4) begin
            errors++;
            $display("FAIL bp_done: got v=%b cnt=%0d expected 0/4", out_valid, hit_count);
        end
    endtask

    task automatic test_stream();
        int outs = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic [3:0] s;
            s = 4'(i);
            drive(1'b1, s, MATCH, good_par(s, MATCH), 1'b1);
            if (out_valid === 1'b1) outs++;
            checks++;
            if (out_valid !== 1'b1 || out_onehot !== 16'(2 ** i % 65536 == 0 ? 0 : 0) + 16'(1 << (i % 16))
                || hit_count !== 4'((i + 1 < CNT_MAX) ? i + 1 : CNT_MAX)) begin
                errors++;
                $display("FAIL stream_%0d: got v=%b oh=%h cnt=%0d", i, out_valid, out_onehot, hit_count);
            end
        end
        checks++;
        if (outs != 20 || hit_count !== 4'd15) begin
            errors++; $display("FAIL stream_total: got outs=%0d cnt=%0d expected 20/15", outs, hit_count);
        end
        idle(1'b1);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'd5, MATCH, good_par(4'd5, MATCH), 1'b0);
        drive(1'b1, 4'd7, MATCH, good_par(4'd7, MATCH), 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL mid_full: got %b expected 0", in_ready);
        end
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || hit_count !== 4'd0) begin
            errors++; $display("FAIL mid_reset: got v=%b cnt=%0d expected 0/0", out_valid, hit_count);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        mq.delete();
        m_cnt = 0;
        m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_release: got rdy=%b v=%b expected 1/0", in_ready, out_valid);
        end
    endtask

`ifdef DECODE_PARITY_EN
    task automatic test_parity();
        int c0;
        c0 = m_cnt;
        drive(1'b1, 4'd2, MATCH, ~good_par(4'd2, MATCH), 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_onehot !== 16'h0000 || out_hit !== 1'b0
            || err_sticky !== 1'b1 || hit_count !== 4'(c0)) begin
            errors++;
            $display("FAIL parity_bad: got v=%b oh=%h hit=%b err=%b cnt=%0d",
                     out_valid, out_onehot, out_hit, err_sticky, hit_count);
        end
        repeat (3) drive(1'b1, 4'd4, MATCH, good_par(4'd4, MATCH), 1'b1);
        checks++;
        if (err_sticky !== 1'b1 || out_onehot !== 16'h0010) begin
            errors++; $display("FAIL parity_hold: got err=%b oh=%h expected 1/0010", err_sticky, out_onehot);
        end
        do_reset();
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++; $display("FAIL parity_clear: got %b expected 0", err_sticky);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [3:0] s;
            logic [4:0] g;
            bit         p;
            s = 4'($urandom_range(0, 15));
            g = ($urandom_range(0, 1) == 1) ? MATCH : 5'($urandom_range(0, 31));
            p = good_par(s, g);
            if ($urandom_range(0, 7) == 0) p = ~p;
            drive($urandom_range(0, 3) != 0, s, g, p, $urandom_range(0, 2) != 0);
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                errors++;
                $display("FAIL rand_flags_%0d: got v=%b rdy=%b expected occupancy %0d",
                         i, out_valid, in_ready, mq.size());
            end else if (mq.size() > 0 && (out_onehot !== mq[0].oh || out_hit !== mq[0].hit)) begin
                errors++;
                $display("FAIL rand_word_%0d: got %h/%b expected %h/%b",
                         i, out_onehot, out_hit, mq[0].oh, mq[0].hit);
            end
            checks++;
            if (hit_count !== 4'(m_cnt) || err_sticky !== m_err) begin
                errors++;
                $display("FAIL rand_cnt_%0d: got cnt=%0d err=%b expected %0d/%b",
                         i, hit_count, err_sticky, m_cnt, m_err);
            end
            if (i == 200) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_miss();
        test_backpressure();
        test_stream();
        test_reset_mid();
`ifdef DECODE_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
